// File: rtl/gpio_apb_sequencer.sv
// Round-robin arbiter feeding a single APB master: grants one requester, runs SETUP/ACCESS,
// returns read data and error (PSLVERR or PREADY timeout) as one-cycle rsp_valid pulses.
module gpio_apb_sequencer #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [32*NUM_REQ-1:0]   req_addr,
  input  logic [32*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [31:0]             PADDR,
  output logic [31:0]             PWDATA,
  input  logic [31:0]             PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int PTRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state_q;
  logic [PTRW-1:0]     ptr_q;
  logic [CW-1:0]       cnt_q;
  logic [NUM_REQ-1:0]  gnt_q, rsp_valid_q;
  logic [31:0]         rsp_rdata_q, paddr_q, pwdata_q;
  logic                rsp_err_q, psel_q, penable_q, pwrite_q;

  logic                win_vld;
  logic [PTRW-1:0]     win_idx;
  logic [PTRW-1:0]     cand;

  // First requester after the last winner, scanning with wrap-around.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    cand    = ptr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTRW'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      ptr_q       <= PTRW'(NUM_REQ - 1);
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            paddr_q   <= req_addr[32*win_idx +: 32];
            pwdata_q  <= req_wdata[32*win_idx +: 32];
            pwrite_q  <= req_write[win_idx];
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            gnt_q     <= NUM_REQ'(1) << win_idx;
            ptr_q     <= win_idx;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_rdata_q <= pwrite_q ? 32'h0 : PRDATA;
            rsp_err_q   <= PSLVERR;
            rsp_valid_q <= NUM_REQ'(1) << ptr_q;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= IDLE;
          end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= NUM_REQ'(1) << ptr_q;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule
